// File: rtl/sm_matrix_n_pkg.sv
// sm_matrix_n shared types: FSM states, default address map, width helper.
// Consumed by the matrix top and the testbench via import sm_matrix_pkg::*.
package sm_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [31:0] SM_SCR_BASE  = 32'h0000_0000;
  localparam logic [31:0] SM_SCR_MASK  = 32'hE000_0000;
  localparam logic [31:0] SM_AHB_BASE  = 32'h0000_0000;
  localparam logic [31:0] SM_AHB_MASK  = 32'h0000_0000;
  localparam logic [31:0] SM_ERR_RDATA = 32'h0000_0000;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_matrix_n_if.sv
// sm_matrix_n bus: core request/response plus the shared slave fan-out.
// slave modport is the matrix side; master modport is the core/slave environment.
interface sm_matrix_n_if #(
  parameter int NSLV = 2
);
  logic [31:0]        a;
  logic               we;
  logic [31:0]        wd;
  logic               valid;
  logic               ready;
  logic [31:0]        rd;
  logic               err;
  logic [NSLV-1:0]    s_valid;
  logic [31:0]        s_addr;
  logic               s_we;
  logic [31:0]        s_wdata;
  logic [NSLV-1:0]    s_ready;
  logic [NSLV*32-1:0] s_rdata;
  logic [NSLV-1:0]    s_err;

  modport slave (
    input  a, we, wd, valid,
    input  s_ready, s_rdata, s_err,
    output ready, rd, err,
    output s_valid, s_addr, s_we, s_wdata
  );

  modport master (
    output a, we, wd, valid,
    output s_ready, s_rdata, s_err,
    input  ready, rd, err,
    input  s_valid, s_addr, s_we, s_wdata
  );
endinterface

// File: rtl/sm_matrix_n_decoder.sv
// sm_matrix_n address decoder: base/mask compare, lowest index wins.
// Produces a one-hot select and a hit flag.
module sm_matrix_n_decoder #(
  parameter int                 NSLV      = 2,
  parameter logic [NSLV*32-1:0] ADDR_BASE = '0,
  parameter logic [NSLV*32-1:0] ADDR_MASK = '0
) (
  input  logic [31:0]     i_a,
  output logic [NSLV-1:0] o_sel,
  output logic            o_hit
);

  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!o_hit &&
          ((i_a & ADDR_MASK[32*i +: 32]) ==
           (ADDR_BASE[32*i +: 32] & ADDR_MASK[32*i +: 32]))) begin
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm_matrix_n.sv
// sm_matrix_n: one master to NSLV slaves with registered req/resp stages.
// Optional slave watchdog under SM_MATRIX_N_TIMEOUT_EN.
module sm_matrix_n
  import sm_matrix_pkg::*;
#(
  parameter int                 NSLV      = 2,
  parameter logic [NSLV*32-1:0] ADDR_BASE = {SM_AHB_BASE, SM_SCR_BASE},
  parameter logic [NSLV*32-1:0] ADDR_MASK = {SM_AHB_MASK, SM_SCR_MASK},
  parameter int                 TIMEOUT   = 255
) (
  input logic          clk,
  input logic          rst,
  sm_matrix_n_if.slave bus
);

  localparam int IW = idx_w(NSLV);

  if (NSLV < 1 || NSLV > 8 || TIMEOUT < 2 || TIMEOUT > 65535)
  begin : g_bad_cfg
    $error("sm_matrix_n: parameter out of range");
  end

  state_t          r_state;
  state_t          w_next;
  logic [NSLV-1:0] r_sel;
  logic [31:0]     r_addr;
  logic            r_we;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rd;
  logic            r_err;

  logic [NSLV-1:0] w_sel;
  logic            w_hit;
  logic [IW-1:0]   w_idx;
  logic            w_rdy;
  logic            w_serr;
  logic [31:0]     w_rdata;
  logic            w_start;
  logic            w_cap;
  logic            w_derr;
  logic            w_tout;

  sm_matrix_n_decoder #(
    .NSLV      (NSLV),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_MASK (ADDR_MASK)
  ) u_dec (
    .i_a   (bus.a),
    .o_sel (w_sel),
    .o_hit (w_hit)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_sel[i]) w_idx = IW'(i);
    end
  end

  // Other slaves' s_ready/s_err are masked off by the latched select.
  assign w_rdy   = |(bus.s_ready & r_sel);
  assign w_serr  = |(bus.s_err & r_sel);
  assign w_rdata = bus.s_rdata[w_idx*32 +: 32];

`ifdef SM_MATRIX_N_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          w_lim;

  assign w_lim = (r_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == REQ || r_state == WAIT) &&
                 !w_rdy && !w_tout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_cap   = 1'b0;
    w_derr  = 1'b0;
    w_tout  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.valid) begin
          w_start = 1'b1;
          if (w_hit) begin
            w_next = REQ;
          end else begin
            w_next = RESP;
            w_derr = 1'b1;
          end
        end
      end
      REQ, WAIT: begin
        if (w_rdy) begin
          w_cap  = 1'b1;
          w_next = RESP;
        end
`ifdef SM_MATRIX_N_TIMEOUT_EN
        else if (w_lim) begin
          w_tout = 1'b1;
          w_next = RESP;
        end
`endif
        else begin
          w_next = WAIT;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_sel   <= w_sel;
        r_addr  <= bus.a;
        r_we    <= bus.we;
        r_wdata <= bus.wd;
      end
      if (w_derr || w_tout) begin
        r_rd  <= SM_ERR_RDATA;
        r_err <= 1'b1;
      end else if (w_cap) begin
        r_rd  <= w_rdata;
        r_err <= w_serr;
      end
    end
  end

  assign bus.ready   = (r_state == RESP);
  assign bus.rd      = r_rd;
  assign bus.err     = r_err;
  assign bus.s_valid = (r_state == REQ) ? r_sel : '0;
  assign bus.s_addr  = r_addr;
  assign bus.s_we    = r_we;
  assign bus.s_wdata = r_wdata;

endmodule

// File: tb/tb_sm_matrix_n.sv
// Directed-vector bench for sm_matrix_n (default, 3-slave and timeout builds).
// Each task drives one scenario and checks against hand-computed values.
module tb_sm_matrix_n;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  localparam logic [95:0] B3 = {32'h4000_0000, 32'h8000_0000, 32'h0000_0000};
  localparam logic [95:0] M3 = {32'hFFFF_0000, 32'h8000_0000, 32'hE000_0000};

  sm_matrix_n_if #(.NSLV(2)) bus2 ();
  sm_matrix_n_if #(.NSLV(3)) bus3 ();

  sm_matrix_n #(.NSLV(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  sm_matrix_n #(
    .NSLV      (3),
    .ADDR_BASE (B3),
    .ADDR_MASK (M3)
  ) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

`ifdef SM_MATRIX_N_TIMEOUT_EN
  sm_matrix_n_if #(.NSLV(2)) bust ();
  sm_matrix_n #(.NSLV(2), .TIMEOUT(4)) u_dutt (
    .clk (clk),
    .rst (rst),
    .bus (bust)
  );
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus2.a = '0; bus2.we = 0; bus2.wd = '0; bus2.valid = 0;
    bus2.s_ready = '0; bus2.s_err = '0; bus2.s_rdata = '0;
    bus3.a = '0; bus3.we = 0; bus3.wd = '0; bus3.valid = 0;
    bus3.s_ready = '0; bus3.s_err = '0; bus3.s_rdata = '0;
`ifdef SM_MATRIX_N_TIMEOUT_EN
    bust.a = '0; bust.we = 0; bust.wd = '0; bust.valid = 0;
    bust.s_ready = '0; bust.s_err = '0; bust.s_rdata = '0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    tick(); tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.s_valid} !== 4'b0)
      $display("FAIL reset_ctl: got %b want 0000",
               {bus2.ready, bus2.err, bus2.s_valid});
    else n_pass++;
    n_chk++;
    if ({bus2.rd, bus2.s_addr, bus2.s_we, bus2.s_wdata} !== 97'h0)
      $display("FAIL reset_data: got %h want 0",
               {bus2.rd, bus2.s_addr, bus2.s_we, bus2.s_wdata});
    else n_pass++;
    rst = 1'b0;
    tick();
    n_chk++;
    if ({bus3.ready, bus3.s_valid} !== 4'b0)
      $display("FAIL reset_n3: got %b want 0000",
               {bus3.ready, bus3.s_valid});
    else n_pass++;
  endtask

  task automatic test_read0();
    bus2.a = 32'h0000_0010; bus2.we = 0; bus2.valid = 1;
    tick();
    n_chk++;
    if (bus2.s_valid !== 2'b01)
      $display("FAIL rd0_svalid: got %b want 01", bus2.s_valid);
    else n_pass++;
    n_chk++;
    if ({bus2.ready, bus2.s_addr} !== {1'b0, 32'h0000_0010})
      $display("FAIL rd0_addr: got %h want 000000010",
               {bus2.ready, bus2.s_addr});
    else n_pass++;
    bus2.s_ready = 2'b01;
    bus2.s_rdata = {32'h0, 32'h1234_5678};
    tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd} !== {2'b10, 32'h1234_5678})
      $display("FAIL rd0_resp: got %h want 212345678",
               {bus2.ready, bus2.err, bus2.rd});
    else n_pass++;
    bus2.valid = 0; bus2.s_ready = '0;
    tick();
    n_chk++;
    if (bus2.ready !== 1'b0)
      $display("FAIL rd0_oneshot: got %b want 0", bus2.ready);
    else n_pass++;
  endtask

  task automatic test_write_wait();
    bus2.a = 32'h2000_0004; bus2.we = 1;
    bus2.wd = 32'hCAFE_F00D; bus2.valid = 1;
    tick();
    n_chk++;
    if ({bus2.s_valid, bus2.s_we, bus2.s_addr, bus2.s_wdata} !==
        {2'b10, 1'b1, 32'h2000_0004, 32'hCAFE_F00D})
      $display("FAIL wr_req: got %h want %h",
               {bus2.s_valid, bus2.s_we, bus2.s_addr, bus2.s_wdata},
               {2'b10, 1'b1, 32'h2000_0004, 32'hCAFE_F00D});
    else n_pass++;
    bus2.s_ready = 2'b01; bus2.a = 32'h0;
    tick();
    n_chk++;
    if ({bus2.s_valid, bus2.ready} !== 3'b000)
      $display("FAIL wr_wait1: got %b want 000",
               {bus2.s_valid, bus2.ready});
    else n_pass++;
    bus2.s_ready = 2'b00;
    tick();
    bus2.s_ready = 2'b01;
    tick();
    n_chk++;
    if ({bus2.ready, bus2.s_addr} !== {1'b0, 32'h2000_0004})
      $display("FAIL wr_wait3: got %h want 020000004",
               {bus2.ready, bus2.s_addr});
    else n_pass++;
    bus2.s_ready = 2'b10;
    bus2.s_rdata = {32'hDEAD_BEEF, 32'h0};
    tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd} !== {2'b10, 32'hDEAD_BEEF})
      $display("FAIL wr_resp: got %h want 2deadbeef",
               {bus2.ready, bus2.err, bus2.rd});
    else n_pass++;
    bus2.valid = 0; bus2.we = 0; bus2.s_ready = '0;
    tick();
  endtask

  task automatic test_slave_err();
    bus2.a = 32'h8000_0000; bus2.valid = 1;
    tick();
    n_chk++;
    if (bus2.s_valid !== 2'b10)
      $display("FAIL serr_svalid: got %b want 10", bus2.s_valid);
    else n_pass++;
    bus2.s_ready = 2'b10; bus2.s_err = 2'b10;
    bus2.s_rdata = {32'hFFFF_FFFF, 32'h1111_1111};
    tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd} !== {2'b11, 32'hFFFF_FFFF})
      $display("FAIL serr_resp: got %h want 3ffffffff",
               {bus2.ready, bus2.err, bus2.rd});
    else n_pass++;
    bus2.valid = 0; bus2.s_ready = '0; bus2.s_err = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus2.a = 32'h0000_0100; bus2.valid = 1;
    tick();
    bus2.s_ready = 2'b01;
    bus2.s_rdata = {32'h0, 32'hAAAA_0001};
    tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd} !== {2'b10, 32'hAAAA_0001})
      $display("FAIL b2b_first: got %h want 2aaaa0001",
               {bus2.ready, bus2.err, bus2.rd});
    else n_pass++;
    bus2.a = 32'h2000_0000; bus2.s_ready = '0;
    tick();
    n_chk++;
    if ({bus2.ready, bus2.s_valid} !== 3'b000)
      $display("FAIL b2b_idle: got %b want 000",
               {bus2.ready, bus2.s_valid});
    else n_pass++;
    tick();
    n_chk++;
    if ({bus2.s_valid, bus2.s_addr} !== {2'b10, 32'h2000_0000})
      $display("FAIL b2b_req2: got %h want 220000000",
               {bus2.s_valid, bus2.s_addr});
    else n_pass++;
    bus2.s_ready = 2'b10;
    bus2.s_rdata = {32'hBBBB_0002, 32'h0};
    tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd} !== {2'b10, 32'hBBBB_0002})
      $display("FAIL b2b_second: got %h want 2bbbb0002",
               {bus2.ready, bus2.err, bus2.rd});
    else n_pass++;
    bus2.valid = 0; bus2.s_ready = '0;
    tick();
  endtask

  task automatic test_decode_err();
    bus3.a = 32'h4000_1234; bus3.valid = 1;
    tick();
    n_chk++;
    if (bus3.s_valid !== 3'b100)
      $display("FAIL n3_svalid: got %b want 100", bus3.s_valid);
    else n_pass++;
    bus3.s_ready = 3'b100;
    bus3.s_rdata = {32'hA5A5_0001, 64'h0};
    tick();
    n_chk++;
    if ({bus3.ready, bus3.err, bus3.rd} !== {2'b10, 32'hA5A5_0001})
      $display("FAIL n3_resp: got %h want 2a5a50001",
               {bus3.ready, bus3.err, bus3.rd});
    else n_pass++;
    bus3.a = 32'h5000_0000; bus3.s_ready = '0;
    tick();
    tick();
    n_chk++;
    if ({bus3.ready, bus3.err, bus3.rd, bus3.s_valid} !==
        {2'b11, 32'h0, 3'b000})
      $display("FAIL dec_err: got %h want %h",
               {bus3.ready, bus3.err, bus3.rd, bus3.s_valid},
               {2'b11, 32'h0, 3'b000});
    else n_pass++;
    bus3.valid = 0;
    tick();
    n_chk++;
    if ({bus3.ready, bus3.s_valid} !== 4'b0)
      $display("FAIL dec_after: got %b want 0000",
               {bus3.ready, bus3.s_valid});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus2.a = 32'h2000_0000; bus2.we = 1;
    bus2.wd = 32'h0000_0055; bus2.valid = 1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd, bus2.s_valid,
         bus2.s_addr, bus2.s_we, bus2.s_wdata} !== 101'h0)
      $display("FAIL rst_mid: got %h want 0",
               {bus2.ready, bus2.err, bus2.rd, bus2.s_valid,
                bus2.s_addr, bus2.s_we, bus2.s_wdata});
    else n_pass++;
    bus2.valid = 0; bus2.we = 0;
    tick();
    rst = 1'b0;
    tick();
    bus2.s_ready = 2'b10;
    bus2.s_rdata = {32'h0000_0999, 32'h0};
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus2.s_ready = '0;
      if (bus2.ready) seen = 1;
    end
    n_chk++;
    if ({seen, bus2.rd} !== 33'h0)
      $display("FAIL rst_late: got %h want 0", {seen, bus2.rd});
    else n_pass++;
    bus2.a = 32'h0000_0010; bus2.valid = 1;
    tick();
    bus2.s_ready = 2'b01;
    bus2.s_rdata = {32'h0, 32'h0BAD_CAFE};
    tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd} !== {2'b10, 32'h0BAD_CAFE})
      $display("FAIL rst_recover: got %h want 20badcafe",
               {bus2.ready, bus2.err, bus2.rd});
    else n_pass++;
    bus2.valid = 0; bus2.s_ready = '0;
    tick();
  endtask

`ifdef SM_MATRIX_N_TIMEOUT_EN
  task automatic test_timeout();
    bust.a = 32'h0000_0010; bust.valid = 1;
    tick();
    repeat (4) tick();
    n_chk++;
    if (bust.ready !== 1'b0)
      $display("FAIL tmo_early: got %b want 0", bust.ready);
    else n_pass++;
    tick();
    n_chk++;
    if ({bust.ready, bust.err, bust.rd} !== {2'b11, 32'h0})
      $display("FAIL tmo_resp: got %h want 300000000",
               {bust.ready, bust.err, bust.rd});
    else n_pass++;
    bust.valid = 0;
    bust.s_ready = 2'b01;
    bust.s_rdata = {32'h0, 32'h0000_0077};
    tick();
    bust.s_ready = '0;
    tick();
    n_chk++;
    if ({bust.ready, bust.rd} !== 33'h0)
      $display("FAIL tmo_late: got %h want 0", {bust.ready, bust.rd});
    else n_pass++;
    bust.valid = 1;
    tick();
    repeat (4) tick();
    bust.s_ready = 2'b01;
    tick();
    n_chk++;
    if ({bust.ready, bust.err, bust.rd} !== {2'b10, 32'h0000_0077})
      $display("FAIL tmo_tie: got %h want 200000077",
               {bust.ready, bust.err, bust.rd});
    else n_pass++;
    bust.valid = 0; bust.s_ready = '0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    bit seen;
    seen = 0;
    bus2.a = 32'h0000_0010; bus2.valid = 1;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus2.ready) seen = 1;
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL notmo_hold: got %b want 0", seen);
    else n_pass++;
    bus2.s_ready = 2'b01;
    bus2.s_rdata = {32'h0, 32'h0000_003C};
    tick();
    n_chk++;
    if ({bus2.ready, bus2.err, bus2.rd} !== {2'b10, 32'h0000_003C})
      $display("FAIL notmo_resp: got %h want 20000003c",
               {bus2.ready, bus2.err, bus2.rd});
    else n_pass++;
    bus2.valid = 0; bus2.s_ready = '0;
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read0();
    test_write_wait();
    test_slave_err();
    test_back_to_back();
    test_decode_err();
    test_reset_mid();
`ifdef SM_MATRIX_N_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
